// File: rtl/harmonic_accumulator_pkg.sv
// Shared types and constants for the harmonic accumulator and its MAC datapath.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package harmonic_accumulator_pkg;

    // Sweep controller states, in the order a harmonic is processed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_WAIT_LUT = 3'd2,
        ST_MULT     = 3'd3,
        ST_ACC      = 3'd4,
        ST_OUTPUT   = 3'd5
    } state_t;

    // Harmonic index width; index 255 is the highest reachable harmonic.
    localparam int HARMONIC_WIDTH = 8;

    // Q0.16 amplitude of the fundamental (closest representable value to 1.0).
    localparam logic [15:0] LEVEL_UNITY = 16'hFFFF;

    // Right shift that converts a Q0.16 product back to integer scale.
    localparam int Q16_SHIFT = 16;

    // Output saturation limits for the 16-bit signed mixed sample.
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/harmonic_level_mac.sv
// Sample x level multiply, geometric level decay and signed accumulation for one sweep.
// Latency: sample registered on load, product one cycle later, acc/level updated on acc_en.
// Backpressure: none; strobes come from the sweep controller, one stage per cycle.
module harmonic_level_mac
    import harmonic_accumulator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LEVEL_WIDTH  = 16,
    parameter int ACC_WIDTH    = 24
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset_n,
    input  logic                           clear,
    input  logic                           load_en,
    input  logic                           mult_en,
    input  logic                           acc_en,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_value,
    input  logic [LEVEL_WIDTH-1:0]         level_scale,
    output logic [LEVEL_WIDTH-1:0]         level_next,
    output logic signed [ACC_WIDTH-1:0]    acc
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + LEVEL_WIDTH + 1;

    logic signed [SAMPLE_WIDTH-1:0] sample_q;
    logic [LEVEL_WIDTH-1:0]         level_q;
    logic signed [PROD_WIDTH-1:0]   product_q;
    logic [2*LEVEL_WIDTH-1:0]       level_prod;

    // Decayed level for the next harmonic; the controller also uses it to stop on zero.
    assign level_prod = level_q * level_scale;
    assign level_next = LEVEL_WIDTH'(level_prod >> Q16_SHIFT);

    // Capture the LUT sample, form the signed product, then fold it into the running sum.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sample_q  <= '0;
            level_q   <= LEVEL_UNITY;
            product_q <= '0;
            acc       <= '0;
        end else begin
            if (clear) begin
                acc     <= '0;
                level_q <= LEVEL_UNITY;
            end
            if (load_en) begin
                sample_q <= sample_value;
            end
            if (mult_en) begin
                // Level is unsigned; a zero-extended operand keeps the multiply signed.
                product_q <= sample_q * $signed({1'b0, level_q});
            end
            if (acc_en) begin
                acc     <= acc + ACC_WIDTH'(product_q >>> Q16_SHIFT);
                level_q <= level_next;
            end
        end
    end

endmodule

// File: rtl/harmonic_accumulator.sv
// Walks harmonics 0..N per sample period, sums level-weighted sine samples, emits one saturated sample.
// Latency: 4 cycles per harmonic after i_Sample_Ready, plus 1 cycle to present the result.
// Backpressure: waits on i_Sample_Ready per harmonic; i_Start while busy is dropped and flagged on o_Overrun.
module harmonic_accumulator
    import harmonic_accumulator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LEVEL_WIDTH  = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int OUT_SHIFT    = 2
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset_n,
    input  logic                           i_Start,
    input  logic [HARMONIC_WIDTH-1:0]      i_Max_Harmonic,
    input  logic [LEVEL_WIDTH-1:0]         i_Level_Scale,
    input  logic                           i_Sample_Ready,
    input  logic signed [SAMPLE_WIDTH-1:0] i_Sample_Value,
    input  logic                           i_Freq_Too_High,
    output logic [HARMONIC_WIDTH-1:0]      o_Harmonic,
    output logic                           o_Next_Sample,
    output logic signed [SAMPLE_WIDTH-1:0] o_Sample_Out,
    output logic                           o_Sample_Valid,
    output logic                           o_Busy,
    output logic                           o_Overrun
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_SAT_MAX = ACC_WIDTH'(SAT_MAX);
    localparam logic signed [ACC_WIDTH-1:0] ACC_SAT_MIN = ACC_WIDTH'(SAT_MIN);

    state_t state_q;
    state_t state_d;

    logic                           mac_clear;
    logic                           mac_load;
    logic                           mac_mult;
    logic                           mac_acc;
    logic [LEVEL_WIDTH-1:0]         level_next;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    acc_shifted;
    logic signed [SAMPLE_WIDTH-1:0] sat_value;
    logic                           last_harmonic;

    harmonic_level_mac #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .LEVEL_WIDTH  (LEVEL_WIDTH),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_mac (
        .i_Clock      (i_Clock),
        .i_Reset_n    (i_Reset_n),
        .clear        (mac_clear),
        .load_en      (mac_load),
        .mult_en      (mac_mult),
        .acc_en       (mac_acc),
        .sample_value (i_Sample_Value),
        .level_scale  (i_Level_Scale),
        .level_next   (level_next),
        .acc          (acc)
    );

    // Sweep ends after the current harmonic is summed: index limit, next harmonic inaudible, or level gone.
    assign last_harmonic = (o_Harmonic == i_Max_Harmonic) || i_Freq_Too_High || (level_next == '0);

    // Scale the sum down and clamp it into the signed output range.
    always_comb begin
        acc_shifted = acc >>> OUT_SHIFT;
        sat_value   = acc_shifted[SAMPLE_WIDTH-1:0];
        if (acc_shifted > ACC_SAT_MAX) begin
            sat_value = SAT_MAX;
        end else if (acc_shifted < ACC_SAT_MIN) begin
            sat_value = SAT_MIN;
        end
    end

    // State register.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d   = state_q;
        mac_clear = 1'b0;
        mac_load  = 1'b0;
        mac_mult  = 1'b0;
        mac_acc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    mac_clear = 1'b1;
                    state_d   = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                // Ready seen alongside our own Next_Sample pulse still belongs to the harmonic just consumed.
                if (i_Sample_Ready && !o_Next_Sample) begin
                    state_d = ST_WAIT_LUT;
                end
            end
            ST_WAIT_LUT: begin
                mac_load = 1'b1;
                state_d  = ST_MULT;
            end
            ST_MULT: begin
                mac_mult = 1'b1;
                state_d  = ST_ACC;
            end
            ST_ACC: begin
                mac_acc = 1'b1;
                state_d = last_harmonic ? ST_OUTPUT : ST_WAIT_RDY;
            end
            ST_OUTPUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered handshake and result outputs; o_Harmonic moves only together with o_Next_Sample.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Harmonic     <= '0;
            o_Next_Sample  <= 1'b0;
            o_Sample_Out   <= '0;
            o_Sample_Valid <= 1'b0;
            o_Busy         <= 1'b0;
            o_Overrun      <= 1'b0;
        end else begin
            o_Next_Sample  <= (state_q == ST_ACC);
            o_Sample_Valid <= (state_q == ST_OUTPUT);
            o_Overrun      <= i_Start && (state_q != ST_IDLE);
            if (state_q == ST_IDLE && i_Start) begin
                o_Busy <= 1'b1;
            end else if (state_q == ST_OUTPUT) begin
                o_Busy <= 1'b0;
            end
            if (state_q == ST_ACC) begin
                o_Harmonic <= last_harmonic ? '0 : o_Harmonic + HARMONIC_WIDTH'(1);
            end
            if (state_q == ST_OUTPUT) begin
                o_Sample_Out <= sat_value;
            end
        end
    end

endmodule

// File: tb/tb_harmonic_accumulator.sv
// Randomised scoreboard bench for harmonic_accumulator with a behavioural sample producer.
// Latency: n/a.
// Backpressure: the producer model inserts random Ready delays per harmonic.
`timescale 1ns/1ps
module tb_harmonic_accumulator;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Start = 1'b0;
    logic [7:0]  i_Max_Harmonic = '0;
    logic [15:0] i_Level_Scale = '0;
    logic        i_Sample_Ready = 1'b0;
    logic [15:0] i_Sample_Value = '0;
    logic        i_Freq_Too_High = 1'b0;
    logic [7:0]  o_Harmonic;
    logic        o_Next_Sample;
    logic [15:0] o_Sample_Out;
    logic        o_Sample_Valid;
    logic        o_Busy;
    logic        o_Overrun;

    harmonic_accumulator dut (
        .i_Clock         (i_Clock),
        .i_Reset_n       (i_Reset_n),
        .i_Start         (i_Start),
        .i_Max_Harmonic  (i_Max_Harmonic),
        .i_Level_Scale   (i_Level_Scale),
        .i_Sample_Ready  (i_Sample_Ready),
        .i_Sample_Value  (i_Sample_Value),
        .i_Freq_Too_High (i_Freq_Too_High),
        .o_Harmonic      (o_Harmonic),
        .o_Next_Sample   (o_Next_Sample),
        .o_Sample_Out    (o_Sample_Out),
        .o_Sample_Valid  (o_Sample_Valid),
        .o_Busy          (o_Busy),
        .o_Overrun       (o_Overrun)
    );

    initial forever #5 i_Clock = ~i_Clock;

    logic signed [15:0] samp [256];
    int                 fth_idx = -1;
    logic [15:0]        exp_out_q [$];
    logic [7:0]         exp_harm_q [$];
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 valid_cnt = 0;
    int                 overrun_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer: after Next_Sample (or when idle) drops Ready, re-raises it after a random
    // delay for the harmonic on o_Harmonic; sine data arrives one cycle after Ready.
    initial begin
        int cnt;
        bit pend;
        cnt  = 0;
        pend = 1'b0;
        forever begin
            @(posedge i_Clock);
            #1;
            if (!i_Reset_n || !o_Busy || o_Next_Sample) begin
                i_Sample_Ready  = 1'b0;
                i_Freq_Too_High = 1'b0;
                i_Sample_Value  = 16'h5A5A;
                pend            = 1'b0;
                cnt             = $urandom_range(0, 3);
            end else if (pend) begin
                i_Sample_Value  = samp[o_Harmonic];
                i_Freq_Too_High = (int'(o_Harmonic) == fth_idx);
                pend            = 1'b0;
            end else if (!i_Sample_Ready) begin
                if (cnt == 0) begin
                    i_Sample_Ready = 1'b1;
                    pend           = 1'b1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops expectations as the DUT presents pulses.
    initial begin
        logic       prev_valid;
        logic       prev_ovr;
        logic [7:0] prev_harm;
        prev_valid = 1'b0;
        prev_ovr   = 1'b0;
        prev_harm  = '0;
        forever begin
            @(negedge i_Clock);
            if (i_Reset_n) begin
                if (o_Harmonic != prev_harm) check("harmonic_moves_with_next_sample", 32'(o_Next_Sample), 32'd1);
                if (o_Next_Sample) begin
                    if (exp_harm_q.size() == 0) check("unexpected_next_sample", 32'd1, 32'd0);
                    else check("harmonic_after_next_sample", 32'(o_Harmonic), 32'(exp_harm_q.pop_front()));
                end
                if (o_Sample_Valid) begin
                    valid_cnt++;
                    if (prev_valid) check("valid_pulse_width", 32'd2, 32'd1);
                    if (exp_out_q.size() == 0) check("unexpected_sample_valid", 32'd1, 32'd0);
                    else check("sample_out", 32'(o_Sample_Out), 32'(exp_out_q.pop_front()));
                    check("busy_low_at_valid", 32'(o_Busy), 32'd0);
                end
                if (o_Overrun) begin
                    overrun_cnt++;
                    if (prev_ovr) check("overrun_pulse_width", 32'd2, 32'd1);
                end
            end
            prev_valid = o_Sample_Valid;
            prev_ovr   = o_Overrun;
            prev_harm  = o_Harmonic;
        end
    end

    // Reference: geometric level, Q0.16 weighting, termination rules, shift and clamp.
    task automatic model_push(input int max_h, input int scale, input int fth);
        longint acc;
        longint lvl;
        longint sh;
        int     h;
        bit     last;
        acc = 0;
        lvl = 65535;
        h   = 0;
        forever begin
            acc  = acc + ((longint'(samp[h]) * lvl) >>> 16);
            lvl  = (lvl * longint'(scale)) >> 16;
            last = (h == max_h) || (h == fth) || (lvl == 0);
            exp_harm_q.push_back(last ? 8'd0 : 8'(h + 1));
            if (last) break;
            h++;
        end
        sh = acc >>> 2;
        if (sh > 32767) exp_out_q.push_back(16'h7FFF);
        else if (sh < -32768) exp_out_q.push_back(16'h8000);
        else exp_out_q.push_back(16'(sh));
    endtask

    task automatic fill(input bit rnd, input logic [15:0] val);
        for (int i = 0; i < 256; i++) samp[i] = rnd ? 16'($urandom) : val;
    endtask

    task automatic pulse_start();
        @(posedge i_Clock); #1 i_Start = 1'b1;
        @(posedge i_Clock); #1 i_Start = 1'b0;
    endtask

    task automatic run_sweep(input int max_h, input int scale, input int fth, input bit do_ovr);
        int  vc0;
        int  oc0;
        bit  done;
        model_push(max_h, scale, fth);
        i_Max_Harmonic = 8'(max_h);
        i_Level_Scale  = 16'(scale);
        fth_idx        = fth;
        vc0            = valid_cnt;
        oc0            = overrun_cnt;
        pulse_start();
        check("busy_after_start", 32'(o_Busy), 32'd1);
        if (do_ovr) begin
            done = 1'b0;
            for (int c = 0; c < 500 && !done; c++) begin
                @(negedge i_Clock);
                if (o_Harmonic == 8'd1) done = 1'b1;
            end
            if (!done) check("wait_harmonic1_timeout", 32'd0, 32'd1);
            pulse_start();
        end
        done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(posedge i_Clock);
            if (valid_cnt != vc0) done = 1'b1;
        end
        if (!done) begin
            check("sweep_timeout", 32'd0, 32'd1);
            exp_out_q.delete();
            exp_harm_q.delete();
        end
        repeat (3) @(posedge i_Clock);
        check("overrun_count", 32'(overrun_cnt - oc0), do_ovr ? 32'd1 : 32'd0);
        check("harmonics_drained", 32'(exp_harm_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_harmonic"}, 32'(o_Harmonic), 32'd0);
        check({tag, "_next_sample"}, 32'(o_Next_Sample), 32'd0);
        check({tag, "_sample_out"}, 32'(o_Sample_Out), 32'd0);
        check({tag, "_sample_valid"}, 32'(o_Sample_Valid), 32'd0);
        check({tag, "_busy"}, 32'(o_Busy), 32'd0);
        check({tag, "_overrun"}, 32'(o_Overrun), 32'd0);
    endtask

    initial begin
        bit done;
        int mx;
        int sc;
        int ft;
        fill(1'b0, 16'h0000);
        #12;
        check_outputs_zero("reset");
        @(negedge i_Clock);
        i_Reset_n = 1'b1;
        repeat (2) @(posedge i_Clock);

        // Single harmonic.
        fill(1'b0, 16'h4000);
        run_sweep(0, 16'h1234, -1, 1'b0);
        // Halving amplitude over four harmonics.
        run_sweep(3, 16'h8000, -1, 1'b0);
        // Frequency limit reached while serving harmonic 2.
        fill(1'b1, 16'h0000);
        run_sweep(10, 16'hE000, 2, 1'b0);
        // Full 256-harmonic sweeps saturating both ways.
        fill(1'b0, 16'h7FFF);
        run_sweep(255, 16'hFFFF, -1, 1'b0);
        fill(1'b0, 16'h8000);
        run_sweep(255, 16'hFFFF, -1, 1'b0);
        // Start during harmonic 1 is dropped and flagged.
        fill(1'b1, 16'h0000);
        run_sweep(4, 16'hC000, -1, 1'b1);
        run_sweep(4, 16'hC000, -1, 1'b0);

        // Asynchronous reset mid-sweep at harmonic 5.
        fill(1'b1, 16'h0000);
        model_push(10, 16'hF000, -1);
        i_Max_Harmonic = 8'd10;
        i_Level_Scale  = 16'hF000;
        fth_idx        = -1;
        pulse_start();
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge i_Clock);
            if (o_Harmonic == 8'd5) done = 1'b1;
        end
        if (!done) check("wait_harmonic5_timeout", 32'd0, 32'd1);
        #2 i_Reset_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (3) @(posedge i_Clock);
        exp_out_q.delete();
        exp_harm_q.delete();
        @(negedge i_Clock);
        i_Reset_n = 1'b1;
        run_sweep(6, 16'hD000, -1, 1'b0);

        // Random sweeps, including tiny scales that decay the level to zero.
        for (int t = 0; t < 10; t++) begin
            fill(1'b1, 16'h0000);
            mx = $urandom_range(0, 15);
            sc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 65535);
            ft = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, mx);
            run_sweep(mx, sc, ft, 1'b0);
        end

        check("outputs_drained", 32'(exp_out_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/harmonic_accumulator.md
Name: harmonic_accumulator

Overview:
Consumer end of the per-harmonic sample handshake. Once per output sample period it walks the harmonic index from 0 upward, waits for each harmonic's sine sample, weights it by a geometrically decaying amplitude and sums it. It stops on the last harmonic, on frequency-too-high, or when the amplitude decays to zero. It then presents one saturated mixed sample to the DAC/output stage.

Parameters:
SAMPLE_WIDTH, 16, width of the signed sine sample from the sample-position block
LEVEL_WIDTH, 16, width of the unsigned amplitude level and scale (Q0.16)
ACC_WIDTH, 24, signed accumulator width (covers 256 full-scale harmonics)
OUT_SHIFT, 2, arithmetic right shift applied to the accumulator before saturation

Ports:
i_Clock  in  1  system clock, single clock domain
i_Reset_n  in  1  reset, asynchronous, active-low
i_Start  in  1  sample-rate strobe, one cycle; begins a harmonic sweep
i_Max_Harmonic  in  8  highest harmonic index to include
i_Level_Scale  in  16  per-harmonic amplitude decay multiplier (Q0.16)
i_Sample_Ready  in  1  sample-position block has loaded the current harmonic
i_Sample_Value  in  16  signed sine sample for the current harmonic
i_Freq_Too_High  in  1  next harmonic is above the audible limit
o_Harmonic  out  8  harmonic index driven to the sample-position block
o_Next_Sample  out  1  one-cycle pulse: current sample consumed
o_Sample_Out  out  16  signed mixed output sample
o_Sample_Valid  out  1  one-cycle pulse when o_Sample_Out updates
o_Busy  out  1  high from accepted i_Start until o_Sample_Valid
o_Overrun  out  1  one-cycle pulse when i_Start arrives while busy

Behaviour:
- Reset (asynchronous, i_Reset_n low): all outputs 0, accumulator 0, Level=16'hFFFF, state IDLE.
- Reset mid-sweep aborts immediately. No partial result is output.
- States: IDLE, WAIT_RDY, WAIT_LUT, MULT, ACC, OUTPUT.
- IDLE: o_Harmonic=0.
  - On i_Start: clear accumulator, Level=16'hFFFF, o_Busy=1, go to WAIT_RDY.
- WAIT_RDY: wait for i_Sample_Ready=1, then go to WAIT_LUT.
  - The sine LUT is a registered read, so data is not yet valid in this cycle.
- WAIT_LUT: register i_Sample_Value, then go to MULT.
- MULT: Product = signed sample × {1'b0,Level} (33-bit signed), registered.
- ACC:
  - Accumulate: Acc += Product>>>16 (sign-extended to ACC_WIDTH).
  - Update level: Level <= (Level × i_Level_Scale)>>16 (unsigned, truncating).
  - Pulse o_Next_Sample for one cycle.
  - Termination: Last = (o_Harmonic == i_Max_Harmonic) OR i_Freq_Too_High OR next Level == 0.
  - i_Freq_Too_High is sampled here, at least 2 cycles after Ready rose, so it is valid.
  - It refers to the next harmonic: the current sample is always accumulated before termination.
  - If Last: o_Harmonic <= 0 in the same cycle as the pulse, so the producer restarts from its init state; go to OUTPUT.
  - Else: o_Harmonic <= o_Harmonic+1; go to WAIT_RDY.
- o_Harmonic changes only in ACC, simultaneously with o_Next_Sample, and is otherwise held stable.
  - This is required because the producer reads its position RAM addressed by o_Harmonic.
- OUTPUT:
  - o_Sample_Out = saturate(Acc>>>OUT_SHIFT) to the range 16'sh8000..16'sh7FFF.
  - Pulse o_Sample_Valid; o_Busy=0; return to IDLE.
  - o_Sample_Out holds its value until the next OUTPUT.
- Latency per harmonic: 4 cycles after Ready rises. Sweep latency is 4·(N+1)+producer latency+1.
- i_Start while o_Busy: ignored, o_Overrun pulses, sweep continues unaffected.
- i_Start coincident with OUTPUT: treated as busy (overrun).
- Harmonic index never exceeds 255. i_Max_Harmonic=255 terminates via the equality test, not wrap.
- i_Max_Harmonic and i_Level_Scale are sampled live, and are expected to change only between sweeps.

Decomposition:
- Shared package: state encoding localparams, LEVEL_UNITY=16'hFFFF, saturation limits, and the Q0.16 shift amount.
- One natural sub-module, harmonic_level_mac: the sample×level multiply, the Level×scale decay and the accumulate. This isolates the DSP/multiplier inference.
- The FSM and handshake stay in the top of this block.

Test Plan:
- Max=0, model returns 0x4000 → one o_Next_Sample with o_Harmonic=0; o_Sample_Out=0x0FFF (0x3FFF>>>2); o_Sample_Valid one pulse.
- Max=3, scale=0x8000, all samples 0x4000:
  - Levels FFFF/7FFF/3FFF/1FFF; terms 3FFF/1FFF/0FFF/07FF.
  - Sum 0x77FC → out 0x1DFF.
  - o_Harmonic sequence 0,1,2,3,0.
- Max=10, model raises Freq_Too_High while serving harmonic 2 → harmonics 0..2 accumulated only; o_Harmonic returns to 0 with the third Next_Sample pulse.
- Max=255, scale=0xFFFF:
  - Samples 0x7FFF → output saturates to 0x7FFF.
  - Samples 0x8000 → output saturates to 0x8000.
- i_Start pulsed during harmonic 1 of a sweep → o_Overrun one-cycle pulse; result identical to an undisturbed sweep.
- i_Reset_n dropped while o_Harmonic=5 → all outputs 0 asynchronously; the next i_Start sweeps from harmonic 0 correctly.
